if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, in-order imem requests, fetch queue feeding IF/ID.
// Optional performance counters are enabled with IF_FETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic [31:0] instr_f,
    output logic [31:0] pc_plus4_f,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects,
`endif
    output logic        instr_valid_f
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DepthC = (CW + 1)'(FQ_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fq_instr_q [FQ_DEPTH];
    logic [31:0]   fq_pc4_q   [FQ_DEPTH];
    logic [31:0]   tag_q      [FQ_DEPTH];
    logic [PW-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CW-1:0] fq_cnt_q, fq_cnt_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          fq_empty, pop, push, hs;
    logic [CW:0]   occupancy;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        fq_empty = (fq_cnt_q == '0);
        pop      = !fq_empty && !stall_d && !redirect_valid;
        // Counting this cycle's pop keeps 1 instr/cycle without risking overflow.
        occupancy = {1'b0, fq_cnt_q} - {{CW{1'b0}}, pop} + {1'b0, in_flight_q};
        imem_req_valid = rst_n && !redirect_valid && (occupancy < DepthC);
        imem_req_addr  = pc_q;
        hs   = imem_req_valid && imem_req_ready;
        push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

        instr_valid_f = !fq_empty;
        instr_f       = fq_empty ? 32'h0 : fq_instr_q[fq_rd_q];
        pc_plus4_f    = fq_empty ? 32'h0 : fq_pc4_q[fq_rd_q];
    end

    always_comb begin
        pc_d        = pc_q;
        fq_rd_d     = fq_rd_q;
        fq_wr_d     = fq_wr_q;
        tag_rd_d    = tag_rd_q;
        tag_wr_d    = tag_wr_q;
        fq_cnt_d    = fq_cnt_q;
        in_flight_d = in_flight_q;
        drop_d      = drop_q;
        if (redirect_valid) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            fq_rd_d     = '0;
            fq_wr_d     = '0;
            tag_rd_d    = '0;
            tag_wr_d    = '0;
            fq_cnt_d    = '0;
            // A response landing this cycle is already gone, so it is not dropped later.
            in_flight_d = in_flight_q - CW'(imem_rsp_valid);
            drop_d      = in_flight_q - CW'(imem_rsp_valid);
        end else begin
            if (hs) begin
                pc_d     = pc_q + 32'd4;
                tag_wr_d = tag_wr_q + PW'(1);
            end
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    fq_wr_d  = fq_wr_q + PW'(1);
                    tag_rd_d = tag_rd_q + PW'(1);
                end
            end
            if (pop) begin
                fq_rd_d = fq_rd_q + PW'(1);
            end
            in_flight_d = in_flight_q + CW'(hs) - CW'(imem_rsp_valid);
            fq_cnt_d    = fq_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            fq_rd_q     <= '0;
            fq_wr_q     <= '0;
            tag_rd_q    <= '0;
            tag_wr_q    <= '0;
            fq_cnt_q    <= '0;
            in_flight_q <= '0;
            drop_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            fq_rd_q     <= fq_rd_d;
            fq_wr_q     <= fq_wr_d;
            tag_rd_q    <= tag_rd_d;
            tag_wr_q    <= tag_wr_d;
            fq_cnt_q    <= fq_cnt_d;
            in_flight_q <= in_flight_d;
            drop_q      <= drop_d;
        end
    end

    // Storage arrays need no reset; the counters above define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_instr_q[fq_wr_q] <= imem_rsp_data;
            fq_pc4_q[fq_wr_q]   <= tag_q[tag_rd_q];
        end
        if (hs) begin
            tag_q[tag_wr_q] <= pc_q + 32'd4;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_redirects_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q   <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order, variable-latency memory model.
// Define IF_FETCH_PERF_CNT_EN to also check the performance counters.
module tb_if_fetch_unit;

    localparam logic [31:0] DataKey = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic [31:0] instr_f;
    logic [31:0] pc_plus4_f;
    logic        instr_valid_f;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        int          t;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_pc4[$];
    logic [31:0] pop_instr[$];
    int          cyc = 0;
    int          mem_lat = 1;

    if_fetch_unit #(
        .RESET_PC(32'h0000_0100),
        .FQ_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall_d       (stall_d),
        .instr_f       (instr_f),
        .pc_plus4_f    (pc_plus4_f),
`ifdef IF_FETCH_PERF_CNT_EN
        .perf_fetched  (perf_fetched),
        .perf_redirects(perf_redirects),
`endif
        .instr_valid_f (instr_valid_f)
    );

    always #5 clk = ~clk;

    // Memory model, request log and IF/ID pop monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (imem_rsp_valid && mq.size() > 0) mq.delete(0);
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc});
                req_log.push_back(imem_req_addr);
            end
            if (instr_valid_f && !stall_d && !redirect_valid) begin
                pop_pc4.push_back(pc_plus4_f);
                pop_instr.push_back(instr_f);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mq.size() > 0 && (cyc - mq[0].t) >= mem_lat) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mq[0].addr ^ DataKey;
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc4);
        return (pc4 - 32'd4) ^ DataKey;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0000_0100);
        chk({tag, "_instr"}, instr_f, 32'h0);
        chk({tag, "_pc4"}, pc_plus4_f, 32'h0);
        chk({tag, "_valid"}, {31'h0, instr_valid_f}, 32'h0);
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc4.delete();
        pop_instr.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        stall_d = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("rst");

        // Streaming from RESET_PC with 1-cycle memory.
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("first_req_addr", imem_req_addr, 32'h0000_0100);
        @(negedge clk); #1;
        chk("no_fast_path", {31'h0, instr_valid_f}, 32'h0);
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk); #1;
            chk("stream_valid", {31'h0, instr_valid_f}, 32'h1);
            chk("stream_pc4", pc_plus4_f, 32'h100 + 32'(4 * (c - 1)));
            chk("stream_instr", instr_f, exp_instr(32'h100 + 32'(4 * (c - 1))));
        end

        // Stall five cycles: head held, requests stop once the queue is full.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stall_d = 1'b1;
            #1;
            chk("stall_pc4", pc_plus4_f, 32'h0000_011C);
            chk("stall_valid", {31'h0, instr_valid_f}, 32'h1);
            chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            stall_d = 1'b0;
        end

        // Mid-stream reset; first confirm nothing was lost or duplicated.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("pop_count", 32'(pop_pc4.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk("pop_pc4_seq", q_at(pop_pc4, i), 32'h104 + 32'(4 * i));
            chk("pop_instr_seq", q_at(pop_instr, i), exp_instr(32'h104 + 32'(4 * i)));
        end
        clear_logs();
        @(negedge clk); #1;
        chk_reset_outputs("midrst");
        mem_lat = 3;

        // Two requests in flight at latency 3, then redirect to 0x2003.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("restart_addr", imem_req_addr, 32'h0000_0100);
        chk("restart_valid", {31'h0, imem_req_valid}, 32'h1);
        @(negedge clk); #1;
        chk("second_req_addr", imem_req_addr, 32'h0000_0104);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2003;
        #1;
        chk("redir_req_valid", {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("redir_target_addr", imem_req_addr, 32'h0000_2000);
        chk("redir_flush_valid", {31'h0, instr_valid_f}, 32'h0);
        repeat (10) @(negedge clk);
        #1;
        chk("redir_req0", q_at(req_log, 0), 32'h0000_0100);
        chk("redir_req1", q_at(req_log, 1), 32'h0000_0104);
        chk("redir_req2", q_at(req_log, 2), 32'h0000_2000);
        chk("redir_first_pc4", q_at(pop_pc4, 0), 32'h0000_2004);
        chk("redir_first_instr", q_at(pop_instr, 0), exp_instr(32'h0000_2004));
        chk("redir_second_pc4", q_at(pop_pc4, 1), 32'h0000_2008);

        // Ready held low for four cycles after reset.
        @(negedge clk);
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        mem_lat = 1;
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("nrdy_valid", {31'h0, imem_req_valid}, 32'h1);
            chk("nrdy_addr", imem_req_addr, 32'h0000_0100);
        end
        @(negedge clk);
        imem_req_ready = 1'b1;
        repeat (12) @(negedge clk);

        // Redirect coinciding with stall, then a back-to-back redirect near the wrap.
        stall_d = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_4000;
        #1;
        chk("pre_redir_valid", {31'h0, instr_valid_f}, 32'h1);
        chk("pre_redir_pc4", pc_plus4_f, 32'h0000_012C);
        chk("nrdy_pop_count", 32'(pop_pc4.size()), 32'd10);
        chk("nrdy_req0", q_at(req_log, 0), 32'h0000_0100);
        chk("nrdy_req1", q_at(req_log, 1), 32'h0000_0104);
`ifdef IF_FETCH_PERF_CNT_EN
        chk("perf_fetched_10", perf_fetched, 32'd10);
`endif
        @(negedge clk);
        stall_d = 1'b0;
        redirect_pc = 32'hFFFF_FFF9;
        #1;
        chk("stall_redir_flush", {31'h0, instr_valid_f}, 32'h0);
        clear_logs();
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("latest_redir_addr", imem_req_addr, 32'hFFFF_FFF8);
        chk("b2b_flush_valid", {31'h0, instr_valid_f}, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
        chk("perf_redirects_2", perf_redirects, 32'd2);
        chk("perf_fetched_hold", perf_fetched, 32'd10);
`endif
        repeat (8) @(negedge clk);
        #1;
        chk("wrap_req0", q_at(req_log, 0), 32'hFFFF_FFF8);
        chk("wrap_req1", q_at(req_log, 1), 32'hFFFF_FFFC);
        chk("wrap_req2", q_at(req_log, 2), 32'h0000_0000);
        chk("wrap_pc4_0", q_at(pop_pc4, 0), 32'hFFFF_FFFC);
        chk("wrap_pc4_1", q_at(pop_pc4, 1), 32'h0000_0000);
        chk("wrap_instr_1", q_at(pop_instr, 1), exp_instr(32'h0000_0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
